// File: rtl/cgra_kernel_dispatcher.sv
// Kernel launch dispatcher: fetches a kernel's config word, allocates contiguous free columns and pulses start (4 cycles accept->start, ALLOC stalls while no fit).
// Defining CGRA_DISPATCH_PERF_EN adds saturating launch/stall counters with a synchronous clear.
module cgra_kernel_dispatcher #(
    parameter int N_COL       = 4,
    parameter int MAX_COL_REQ = 4,
    parameter int KER_ID_W    = 4,
    parameter int IMEM_ADD_W  = 7,
    parameter int N_INSTR_W   = 5,
    parameter int KMEM_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [KER_ID_W-1:0]           req_ker_id_i,
    output logic                          kmem_req_o,
    output logic [KER_ID_W-1:0]           kmem_add_o,
    input  logic [KMEM_WIDTH-1:0]         kmem_rdata_i,
    input  logic [N_COL-1:0]              col_done_i,
    output logic [N_COL-1:0]              col_start_o,
    output logic [N_COL*IMEM_ADD_W-1:0]   col_imem_add_o,
    output logic [N_COL*N_INSTR_W-1:0]    col_n_instr_o,
    output logic [N_COL-1:0]              col_busy_o,
    output logic                          busy_o,
    output logic                          err_o
`ifdef CGRA_DISPATCH_PERF_EN
    ,
    input  logic                          perf_clr_i,
    output logic [31:0]                   perf_n_ker_o,
    output logic [31:0]                   perf_stall_o
`endif
);

    localparam int CF_LSB = IMEM_ADD_W + N_INSTR_W;
    localparam int CF_W   = KMEM_WIDTH - CF_LSB;
    localparam int CNT_W  = $clog2(CF_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ALLOC,
        S_LAUNCH
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [KER_ID_W-1:0]          r_id;
    logic [CNT_W-1:0]             r_cnt;
    logic [IMEM_ADD_W-1:0]        r_add;
    logic [N_INSTR_W-1:0]         r_ninstr;
    logic [N_COL-1:0]             r_mask;
    logic [N_COL-1:0]             r_busy;
    logic                         r_err;
    logic [N_COL*IMEM_ADD_W-1:0]  r_col_add;
    logic [N_COL*N_INSTR_W-1:0]   r_col_ninstr;

    logic [CF_W-1:0]              w_cf;
    logic [CNT_W-1:0]             w_cnt;
    logic                         w_dec_ok;
    logic                         w_found;
    logic [N_COL-1:0]             w_sel;
    logic [N_COL-1:0]             w_cand;
    logic                         w_err_set;

    // Column field must be one-hot; bit k asks for k+1 columns.
    always_comb begin
        w_cf  = kmem_rdata_i[KMEM_WIDTH-1:CF_LSB];
        w_cnt = '0;
        for (int k = 0; k < CF_W; k++) begin
            if (w_cf[k]) w_cnt = CNT_W'(k + 1);
        end
        w_dec_ok = (w_cf != '0) && ((w_cf & (w_cf - CF_W'(1))) == '0)
                   && (int'(w_cnt) <= MAX_COL_REQ);
    end

    // Descending scan so the lowest fitting base column wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int b = N_COL - 1; b >= 0; b--) begin
            w_cand = '0;
            for (int i = 0; i < N_COL; i++) begin
                w_cand[i] = (i >= b) && (i < b + int'(r_cnt));
            end
            if ((b + int'(r_cnt) <= N_COL) && ((w_cand & r_busy) == '0)) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (req_ker_id_i == '0) w_err_set = 1'b1;
                    else                    w_next    = S_FETCH;
                end
            end
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_dec_ok) begin
                    w_next = S_ALLOC;
                end else begin
                    w_next    = S_IDLE;
                    w_err_set = 1'b1;
                end
            end
            S_ALLOC:  if (w_found) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_id         <= '0;
            r_cnt        <= '0;
            r_add        <= '0;
            r_ninstr     <= '0;
            r_mask       <= '0;
            r_busy       <= '0;
            r_err        <= 1'b0;
            r_col_add    <= '0;
            r_col_ninstr <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_set;
            if (r_state == S_IDLE && req_valid_i) r_id <= req_ker_id_i;
            if (r_state == S_DECODE) begin
                r_cnt    <= w_cnt;
                r_add    <= kmem_rdata_i[CF_LSB-1:N_INSTR_W];
                r_ninstr <= kmem_rdata_i[N_INSTR_W-1:0];
            end
            if (r_state == S_ALLOC && w_found) r_mask <= w_sel;
            // Done on an idle column is a no-op; launch only targets free columns.
            r_busy <= (r_busy & ~col_done_i) | ((r_state == S_LAUNCH) ? r_mask : '0);
            if (r_state == S_LAUNCH) begin
                for (int c = 0; c < N_COL; c++) begin
                    if (r_mask[c]) begin
                        r_col_add[c*IMEM_ADD_W +: IMEM_ADD_W]   <= r_add;
                        r_col_ninstr[c*N_INSTR_W +: N_INSTR_W]  <= r_ninstr;
                    end
                end
            end
        end
    end

    assign req_ready_o    = (r_state == S_IDLE);
    assign kmem_req_o     = (r_state == S_FETCH);
    assign kmem_add_o     = (r_state == S_FETCH) ? r_id : '0;
    assign col_start_o    = (r_state == S_LAUNCH) ? r_mask : '0;
    assign col_imem_add_o = r_col_add;
    assign col_n_instr_o  = r_col_ninstr;
    assign col_busy_o     = r_busy;
    assign busy_o         = (r_state != S_IDLE) || (|r_busy);
    assign err_o          = r_err;

`ifdef CGRA_DISPATCH_PERF_EN
    logic [31:0] r_perf_n_ker;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_n_ker <= '0;
            r_perf_stall <= '0;
        end else if (perf_clr_i) begin
            r_perf_n_ker <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_state == S_LAUNCH && r_perf_n_ker != '1) r_perf_n_ker <= r_perf_n_ker + 32'd1;
            if (r_state == S_ALLOC && !w_found && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_n_ker_o = r_perf_n_ker;
    assign perf_stall_o = r_perf_stall;
`endif

endmodule
